// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with leading-zero blanking and a timed
// off/on flash sequence on all digits after wrap-around from all nines.
module bcd_score_counter #(
    parameter int NDIG        = 2,
    parameter int HALF_PERIOD = 25,
    parameter int FLASHES     = 3
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   en,
    output logic              ovf,
    output logic              flashing
);

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PW = (FLASHES > 1) ? $clog2(FLASHES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] PMAX = PW'(FLASHES - 1);

    typedef enum logic {S_COUNT, S_FLASH} state_t;
    typedef enum logic {PH_OFF, PH_ON} phase_t;

    state_t              r_state, w_state_nxt;
    phase_t              r_phase, w_phase_nxt;
    logic                r_inc_q;
    logic [4*NDIG-1:0]   r_digits, w_digits_nxt;
    logic [NDIG-1:0]     r_en, w_en_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [PW-1:0]       r_pairs, w_pairs_nxt;

    logic                w_event;
    logic [4*NDIG-1:0]   w_inc_digits;
    logic                w_all_nines;

    // en[i] is set when any digit at or above position i is nonzero.
    function automatic logic [NDIG-1:0] blank_en(input logic [4*NDIG-1:0] d);
        logic [NDIG-1:0] e;
        logic            any_nz;
        e      = '0;
        any_nz = 1'b0;
        for (int unsigned i = NDIG; i > 0; i--) begin
            any_nz   = any_nz | (d[4*(i-1) +: 4] != 4'd0);
            e[i-1]   = any_nz;
        end
        e[0] = 1'b1;
        return e;
    endfunction

    assign w_event = inc & ~r_inc_q;

    // Ripple-carry BCD increment; a carry out of the top digit means all nines.
    always_comb begin
        logic carry;
        carry        = 1'b1;
        w_inc_digits = r_digits;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (r_digits[4*i +: 4] == 4'd9) begin
                    w_inc_digits[4*i +: 4] = 4'd0;
                end else begin
                    w_inc_digits[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        w_all_nines = carry;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_digits_nxt = r_digits;
        w_en_nxt     = r_en;
        w_ovf_nxt    = r_ovf;
        w_timer_nxt  = r_timer;
        w_pairs_nxt  = r_pairs;

        if (clr) begin
            w_state_nxt  = S_COUNT;
            w_phase_nxt  = PH_OFF;
            w_digits_nxt = '0;
            w_en_nxt     = blank_en('0);
            w_ovf_nxt    = 1'b0;
            w_timer_nxt  = '0;
            w_pairs_nxt  = '0;
        end else begin
            case (r_state)
                S_COUNT: begin
                    if (w_event) begin
                        if (w_all_nines) begin
                            w_state_nxt  = S_FLASH;
                            w_phase_nxt  = PH_OFF;
                            w_digits_nxt = '0;
                            w_en_nxt     = '0;
                            w_ovf_nxt    = 1'b1;
                            w_timer_nxt  = '0;
                            w_pairs_nxt  = '0;
                        end else begin
                            w_digits_nxt = w_inc_digits;
                            w_en_nxt     = blank_en(w_inc_digits);
                        end
                    end
                end
                S_FLASH: begin
                    if (r_timer == TMAX) begin
                        w_timer_nxt = '0;
                        if (r_phase == PH_OFF) begin
                            w_phase_nxt = PH_ON;
                            w_en_nxt    = '1;
                        end else if (r_pairs == PMAX) begin
                            w_state_nxt = S_COUNT;
                            w_phase_nxt = PH_OFF;
                            w_pairs_nxt = '0;
                            w_en_nxt    = blank_en(r_digits);
                        end else begin
                            w_phase_nxt = PH_OFF;
                            w_pairs_nxt = r_pairs + 1'b1;
                            w_en_nxt    = '0;
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: w_state_nxt = S_COUNT;
            endcase
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_state  <= S_COUNT;
            r_phase  <= PH_OFF;
            r_inc_q  <= 1'b0;
            r_digits <= '0;
            r_en     <= NDIG'(1);
            r_ovf    <= 1'b0;
            r_timer  <= '0;
            r_pairs  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_inc_q  <= inc;
            r_digits <= w_digits_nxt;
            r_en     <= w_en_nxt;
            r_ovf    <= w_ovf_nxt;
            r_timer  <= w_timer_nxt;
            r_pairs  <= w_pairs_nxt;
        end
    end

    assign digits   = r_digits;
    assign en       = r_en;
    assign ovf      = r_ovf;
    assign flashing = (r_state == S_FLASH);

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed and randomized bench for bcd_score_counter against an integer
// score / elapsed-flash-time reference model.
module tb_bcd_score_counter;

    localparam int NDIG = 2;
    localparam int HP   = 25;
    localparam int FL   = 3;
    localparam int MAXS = 10**NDIG - 1;

    logic              hz100 = 1'b0;
    logic              reset;
    logic              inc;
    logic              clr;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   en;
    logic              ovf;
    logic              flashing;

    int checks = 0;
    int errors = 0;

    int m_score;
    bit m_ovf;
    bit m_flash;
    bit m_incq;
    int m_el;

    bcd_score_counter #(
        .NDIG        (NDIG),
        .HALF_PERIOD (HP),
        .FLASHES     (FL)
    ) dut (
        .hz100    (hz100),
        .reset    (reset),
        .inc      (inc),
        .clr      (clr),
        .digits   (digits),
        .en       (en),
        .ovf      (ovf),
        .flashing (flashing)
    );

    always #5 hz100 = ~hz100;

    function automatic logic [4*NDIG-1:0] exp_digits();
        logic [4*NDIG-1:0] v;
        int s;
        s = m_score;
        for (int i = 0; i < NDIG; i++) begin
            v[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return v;
    endfunction

    function automatic logic [NDIG-1:0] exp_en();
        logic [NDIG-1:0] v;
        int p;
        if (m_flash) return (((m_el / HP) % 2) == 1) ? '1 : '0;
        p = 1;
        for (int i = 0; i < NDIG; i++) begin
            v[i] = (i == 0) || (m_score >= p);
            p = p * 10;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'(exp_digits()));
        check({tag, "_en"}, 32'(en), 32'(exp_en()));
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, "_flashing"}, 32'(flashing), 32'(m_flash));
    endtask

    task automatic model_reset();
        m_score = 0;
        m_ovf   = 1'b0;
        m_flash = 1'b0;
        m_incq  = 1'b0;
        m_el    = 0;
    endtask

    task automatic model_clock();
        bit ev;
        ev     = inc && !m_incq;
        m_incq = inc;
        if (clr) begin
            m_score = 0;
            m_ovf   = 1'b0;
            m_flash = 1'b0;
        end else if (m_flash) begin
            m_el++;
            if (m_el == 2 * FL * HP) m_flash = 1'b0;
        end else if (ev) begin
            if (m_score == MAXS) begin
                m_score = 0;
                m_ovf   = 1'b1;
                m_flash = 1'b1;
                m_el    = 0;
            end else begin
                m_score++;
            end
        end
    endtask

    task automatic step(input logic i_inc, input logic i_clr, input string tag);
        inc = i_inc;
        clr = i_clr;
        @(posedge hz100);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic pulses(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, tag);
            step(1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        inc   = 1'b0;
        clr   = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge hz100);
        reset = 1'b0;

        // Count to 9, then carry into the tens digit.
        pulses(9, "t1");
        check("t1_nine", 32'(digits), 32'h09);
        check("t1_nine_en", 32'(en), 32'b01);
        pulses(1, "t1");
        check("t1_ten", 32'(digits), 32'h10);
        check("t1_ten_en", 32'(en), 32'b11);

        // Held level counts once.
        step(1'b0, 1'b1, "t2clr");
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, "t2");
        check("t2_once", 32'(digits), 32'h01);
        step(1'b0, 1'b0, "t2");

        // Overflow and the full flash sequence.
        step(1'b0, 1'b1, "t3clr");
        pulses(99, "t3");
        step(1'b1, 1'b0, "t3ovf");
        check("t3_ovf_digits", 32'(digits), 32'h00);
        check("t3_ovf_flag", 32'(ovf), 32'd1);
        check("t3_ovf_flashing", 32'(flashing), 32'd1);
        for (int k = 0; k < 2 * FL * HP; k++) step(1'b0, 1'b0, "t3flash");
        check("t3_end_en", 32'(en), 32'b01);
        check("t3_end_flashing", 32'(flashing), 32'd0);
        check("t3_end_ovf", 32'(ovf), 32'd1);

        // inc dropped during flash, clr aborts it.
        step(1'b0, 1'b1, "t4clr");
        pulses(99, "t4");
        step(1'b1, 1'b0, "t4ovf");
        for (int k = 1; k < 60; k++) step(k == 40, 1'b0, "t4flash");
        check("t4_hold_digits", 32'(digits), 32'h00);
        step(1'b0, 1'b1, "t4clr60");
        check("t4_clr_flashing", 32'(flashing), 32'd0);
        check("t4_clr_ovf", 32'(ovf), 32'd0);
        check("t4_clr_en", 32'(en), 32'b01);

        // clr wins over a coincident inc edge.
        pulses(37, "t5");
        check("t5_pre", 32'(digits), 32'h37);
        step(1'b1, 1'b1, "t5clr");
        check("t5_digits", 32'(digits), 32'h00);
        check("t5_en", 32'(en), 32'b01);
        step(1'b0, 1'b0, "t5");

        // Async reset between edges, inc held across release.
        pulses(42, "t6");
        check("t6_pre", 32'(digits), 32'h42);
        #2;
        reset = 1'b1;
        inc   = 1'b1;
        #1;
        model_reset();
        check("t6_async_digits", 32'(digits), 32'h00);
        check("t6_async_en", 32'(en), 32'b01);
        check_all("t6_async");
        @(negedge hz100);
        reset = 1'b0;
        step(1'b1, 1'b0, "t6rel");
        check("t6_one", 32'(digits), 32'h01);
        step(1'b1, 1'b0, "t6hold");

        // Random traffic starting near the top of the range.
        step(1'b0, 1'b1, "rclr");
        pulses(90, "rpre");
        for (int k = 0; k < 600; k++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
